// File: rtl/fetch_queue_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues single-beat reads
// and buffers fetched words with their PCs in a small FIFO toward decode.
module fetch_queue_unit #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  bus_available,
    input  logic                  bus_ready,
    input  logic                  bus_response,
    input  logic [DATA_WIDTH-1:0] bus_read_data,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic                  bus_write,
    output logic                  bus_start,
    output logic                  to_decode_valid,
    input  logic                  to_decode_ready,
    output logic [DATA_WIDTH-1:0] to_decode_data,
    output logic [ADDR_WIDTH-1:0] to_decode_pc,
    output logic                  to_decode_error
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        DISCARD,
        HALTED
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_err;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic issue;
    logic push;
    logic pop;

    assign bus_write       = 1'b0;
    assign to_decode_valid = (count != '0);
    assign to_decode_data  = q_data[head];
    assign to_decode_pc    = q_pc[head];
    assign to_decode_error = q_err[head];

    // A redirect suppresses issue, push and pop on the same edge.
    assign issue = (state == IDLE) && !redirect && bus_available
                   && bus_ready && (count < CW'(QUEUE_DEPTH));
    assign push  = (state == WAITING) && bus_ready && !redirect;
    assign pop   = to_decode_valid && to_decode_ready && !redirect;

    // Fetch control: PC, bus request and transfer-tracking state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            bus_start   <= 1'b0;
            bus_address <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        bus_address <= fetch_pc;
                        bus_start   <= 1'b1;
                        state       <= WAITING;
                    end
                end
                WAITING: begin
                    if (bus_ready) begin
                        bus_start <= 1'b0;
                        if (!redirect && bus_response) begin
                            state <= HALTED;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (redirect) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus_ready) begin
                        bus_start <= 1'b0;
                        state     <= IDLE;
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction FIFO: push on completion, pop on handshake, flush on redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_err <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_data[tail] <= bus_response ? '0 : bus_read_data;
                q_pc[tail]   <= bus_address;
                q_err[tail]  <= bus_response;
                tail         <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bus_available;
    logic        bus_ready;
    logic        bus_response;
    logic [31:0] bus_read_data;
    logic [31:0] bus_address;
    logic        bus_write;
    logic        bus_start;
    logic        to_decode_valid;
    logic        to_decode_ready;
    logic [31:0] to_decode_data;
    logic [31:0] to_decode_pc;
    logic        to_decode_error;

    always #5 clock = ~clock;

    fetch_queue_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .QUEUE_DEPTH(DEPTH),
        .RESET_PC   (32'h0),
        .PC_STEP    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .bus_available  (bus_available),
        .bus_ready      (bus_ready),
        .bus_response   (bus_response),
        .bus_read_data  (bus_read_data),
        .bus_address    (bus_address),
        .bus_write      (bus_write),
        .bus_start      (bus_start),
        .to_decode_valid(to_decode_valid),
        .to_decode_ready(to_decode_ready),
        .to_decode_data (to_decode_data),
        .to_decode_pc   (to_decode_pc),
        .to_decode_error(to_decode_error)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        bit          err;
    } ent_t;

    // Reference model: a plain queue plus a few flags describing the bus.
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_disc;
    bit          m_halt;
    bit          m_start;

    logic [31:0] issued[$];
    ent_t        popped[$];

    int checks = 0;
    int errors = 0;
    bit err_mode = 0;
    bit rand_data = 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] iss(input int i);
        if (i < issued.size()) return issued[i];
        return 'x;
    endfunction

    function automatic ent_t pp(input int i);
        ent_t e;
        e.data = 'x;
        e.pc   = 'x;
        e.err  = 0;
        if (i < popped.size()) e = popped[i];
        return e;
    endfunction

    function automatic void model_step();
        ent_t e;
        int   sz;
        if (reset) begin
            mq.delete();
            m_fpc   = 32'h0;
            m_addr  = 32'h0;
            m_busy  = 0;
            m_disc  = 0;
            m_halt  = 0;
            m_start = 0;
            return;
        end
        if (redirect) begin
            mq.delete();
            m_fpc  = redirect_pc;
            m_halt = 0;
            if (m_busy) begin
                if (bus_ready) begin
                    m_busy  = 0;
                    m_disc  = 0;
                    m_start = 0;
                end else begin
                    m_disc = 1;
                end
            end
            return;
        end
        sz = mq.size();
        if (sz > 0 && to_decode_ready) begin
            popped.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (m_busy) begin
            if (bus_ready) begin
                if (!m_disc) begin
                    e.pc   = m_addr;
                    e.err  = bus_response;
                    e.data = bus_response ? 32'h0 : bus_read_data;
                    mq.push_back(e);
                    if (bus_response) m_halt = 1;
                end
                m_busy  = 0;
                m_disc  = 0;
                m_start = 0;
            end
        end else if (!m_halt && bus_available && bus_ready && sz < DEPTH) begin
            m_addr = m_fpc;
            issued.push_back(m_fpc);
            m_fpc   = m_fpc + 32'd4;
            m_start = 1;
            m_busy  = 1;
        end
    endfunction

    task automatic compare();
        chk("bus_write", bus_write, 1'b0);
        chk("bus_start", bus_start, m_start);
        if (m_start) chk("bus_address", bus_address, m_addr);
        chk("valid", to_decode_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("data", to_decode_data, mq[0].data);
            chk("pc", to_decode_pc, mq[0].pc);
            chk("error", to_decode_error, mq[0].err);
        end
    endtask

    task automatic tick();
        if (rand_data) bus_read_data = $urandom;
        if (err_mode) bus_response = bus_start && (bus_address == 32'h8);
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        reset    = 1;
        redirect = 0;
        tick();
        reset = 0;
        issued.delete();
        popped.delete();
    endtask

    task automatic all_ready();
        bus_available   = 1;
        bus_ready       = 1;
        bus_response    = 0;
        to_decode_ready = 1;
    endtask

    initial begin
        int n;
        reset           = 1;
        redirect        = 0;
        redirect_pc     = 0;
        bus_available   = 0;
        bus_ready       = 0;
        bus_response    = 0;
        bus_read_data   = 0;
        to_decode_ready = 0;

        // Reset state
        do_reset();
        chk("rst_start", bus_start, 1'b0);
        chk("rst_addr", bus_address, 32'h0);
        chk("rst_valid", to_decode_valid, 1'b0);
        chk("rst_data", to_decode_data, 32'h0);
        chk("rst_pc", to_decode_pc, 32'h0);
        chk("rst_err", to_decode_error, 1'b0);

        // Streaming with 1-cycle completion
        all_ready();
        repeat (10) tick();
        chk("A_iss0", iss(0), 32'h0);
        chk("A_iss1", iss(1), 32'h4);
        chk("A_iss2", iss(2), 32'h8);
        chk("A_iss3", iss(3), 32'hc);
        chk("A_pop0", pp(0).pc, 32'h0);
        chk("A_pop1", pp(1).pc, 32'h4);
        chk("A_pop2", pp(2).pc, 32'h8);

        // Decode stalled: prefetch fills exactly DEPTH entries
        do_reset();
        all_ready();
        to_decode_ready = 0;
        repeat (20) tick();
        chk("B_count", issued.size(), 4);
        chk("B_idle", bus_start, 1'b0);
        to_decode_ready = 1;
        repeat (12) tick();
        chk("B_pop0", pp(0).pc, 32'h0);
        chk("B_pop1", pp(1).pc, 32'h4);
        chk("B_pop2", pp(2).pc, 32'h8);
        chk("B_pop3", pp(3).pc, 32'hc);
        chk("B_iss4", iss(4), 32'h10);

        // Redirect while a transfer is stalled
        do_reset();
        all_ready();
        tick();
        bus_ready = 0;
        tick();
        redirect    = 1;
        redirect_pc = 32'h100;
        tick();
        redirect = 0;
        repeat (2) tick();
        bus_ready = 1;
        repeat (8) tick();
        chk("C_iss1", iss(1), 32'h100);
        chk("C_pop0", pp(0).pc, 32'h100);

        // Error response at address 8 halts fetching
        do_reset();
        all_ready();
        err_mode = 1;
        repeat (16) tick();
        chk("D_count", issued.size(), 3);
        chk("D_pc", pp(2).pc, 32'h8);
        chk("D_err", pp(2).err, 1'b1);
        chk("D_data", pp(2).data, 32'h0);
        chk("D_halt", bus_start, 1'b0);
        err_mode     = 0;
        bus_response = 0;
        redirect     = 1;
        redirect_pc  = 32'h40;
        tick();
        redirect = 0;
        repeat (4) tick();
        chk("D_iss3", iss(3), 32'h40);

        // PC wrap-around
        n           = issued.size();
        redirect    = 1;
        redirect_pc = 32'hffff_fffc;
        tick();
        redirect = 0;
        repeat (6) tick();
        chk("E_wrap0", iss(n), 32'hffff_fffc);
        chk("E_wrap1", iss(n + 1), 32'h0);

        // Reset while waiting
        for (int k = 0; k < 5 && !bus_start; k++) tick();
        chk("E_start", bus_start, 1'b1);
        bus_ready = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("E_rst_start", bus_start, 1'b0);
        chk("E_rst_addr", bus_address, 32'h0);
        chk("E_rst_valid", to_decode_valid, 1'b0);
        chk("E_rst_pc", to_decode_pc, 32'h0);

        // Simultaneous push and pop with three entries held
        do_reset();
        all_ready();
        to_decode_ready = 0;
        repeat (7) tick();
        chk("F_head0", to_decode_pc, 32'h0);
        to_decode_ready = 1;
        tick();
        chk("F_pop0", pp(0).pc, 32'h0);
        chk("F_head1", to_decode_pc, 32'h4);
        bus_available = 0;
        repeat (6) tick();
        chk("F_drain", popped.size(), 4);
        chk("F_pop3", pp(3).pc, 32'hc);
        chk("F_noiss", issued.size(), 4);
        chk("F_nostart", bus_start, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus_available   = ($urandom % 8) != 0;
            bus_ready       = ($urandom % 4) != 0;
            bus_response    = ($urandom % 32) == 0;
            to_decode_ready = ($urandom % 3) != 0;
            redirect        = ($urandom % 40) == 0;
            redirect_pc     = ($urandom % 4 == 0) ? 32'hffff_fff0
                                                  : ($urandom & 32'hffff_fffc);
            reset           = ($urandom % 500) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
